// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the sequential BCD adder.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nine's complement of one digit; wraps modulo 16 for invalid (>9) digits.
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder: 4-bit binary add plus decimal correction, purely combinational.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out,
    output logic       invalid
);

    logic [4:0] bin_sum;
    logic       corr;

    assign bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
    assign corr    = bin_sum > {1'b0, BCD_MAX};

    // Adding 6 skips the six unused codes; only the low nibble is kept as the digit.
    assign s       = corr ? 4'(bin_sum + {1'b0, BCD_ADJ}) : bin_sum[3:0];
    assign c_out   = corr;
    assign invalid = (a > BCD_MAX) || (b > BCD_MAX);

endmodule

// File: rtl/bcd_seq_adder.sv
// Multi-cycle BCD adder/subtractor: one digit per clock, LSD first, start/done handshake.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                c_out,
    output logic                err
);

    localparam int             W        = 4 * DIGITS;
    localparam int             IW       = $clog2(DIGITS + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            c_out_q, c_out_d;
    logic            err_q, err_d;

    logic [3:0]      dig_b;
    logic [3:0]      dig_s;
    logic            dig_c;
    logic            dig_inv;

    // Subtraction is ten's complement: nine's complement of B plus an initial carry of 1.
    assign dig_b = sub_q ? nines_comp(b_q[3:0]) : b_q[3:0];

    bcd_digit_adder u_digit (
        .a       (a_q[3:0]),
        .b       (dig_b),
        .c_in    (carry_q),
        .s       (dig_s),
        .c_out   (dig_c),
        .invalid (dig_inv)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    carry_d = sub;
                    sub_d   = sub;
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    c_out_d = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = dig_s;
                carry_d = dig_c;
                err_d   = err_q | dig_inv;
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    c_out_d = dig_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed self-checking bench for bcd_seq_adder with DIGITS=4.
module tb_bcd_seq_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    bcd_seq_adder #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after an edge with the DUT idle; returns 1 unit after the start edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = sv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if ({busy, done, sum, c_out, err} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h c_out=%b err=%b, expected all 0",
                     busy, done, sum, c_out, err);
        end
    endtask

    task automatic test_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                           input logic sv, input logic [15:0] exp_sum, input logic exp_c);
        int lat;
        start_op(av, bv, sv);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy: got busy=%b done=%b, expected busy=1 done=0", name, busy, done);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d cycles, expected 4", name, lat);
        end
        tests_run++;
        if (sum !== exp_sum || c_out !== exp_c || err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_result: got sum=%h c_out=%b err=%b busy=%b, expected sum=%h c_out=%b err=0 busy=0",
                     name, sum, c_out, err, busy, exp_sum, exp_c);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: got done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        start_op(16'h1234, 16'h5678, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        a     = 16'h9999;
        b     = 16'h9999;
        sub   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        tests_run++;
        if (lat !== 2 || sum !== 16'h6912 || c_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start: got lat=%0d sum=%h c_out=%b, expected lat=2 sum=6912 c_out=0",
                     lat, sum, c_out);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(16'h1234, 16'h5678, 1'b0);
        wait_done(lat);
        tests_run++;
        if (lat !== 4 || sum !== 16'h6912) begin
            tests_failed++;
            $display("FAIL b2b_first: got lat=%0d sum=%h, expected lat=4 sum=6912", lat, sum);
        end
        start_op(16'h5000, 16'h1234, 1'b1);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b, expected busy=1 done=0", busy, done);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== 4 || sum !== 16'h3766 || c_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: got lat=%0d sum=%h c_out=%b, expected lat=4 sum=3766 c_out=1",
                     lat, sum, c_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid;
        int lat;
        start_op(16'h00A1, 16'h0001, 1'b0);
        wait_done(lat);
        tests_run++;
        if (lat !== 4 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL invalid_digit: got lat=%0d err=%b, expected lat=4 err=1", lat, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun;
        start_op(16'h1234, 16'h5678, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, sum, c_out, err} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_midrun: got busy=%b done=%b sum=%h c_out=%b err=%b, expected all 0",
                     busy, done, sum, c_out, err);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        test_op("after_reset", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;

        test_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0);
        test_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1);
        test_op("add_0000_0000", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        test_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1);
        test_op("sub_1234_5000", 16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0);
        test_ignore_start();
        test_back_to_back();
        test_invalid();
        test_op("valid_after_err", 16'h0045, 16'h0055, 1'b0, 16'h0100, 1'b0);
        test_reset_midrun();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
